// File: rtl/led_event_sequencer_if.sv
// rtl/led_event_sequencer_if.sv - event handshake bundle between the core and the LED sequencer
interface led_event_sequencer_if;
    logic       ev_valid;
    logic [1:0] ev_op;
    logic [7:0] ev_data;
    logic       ev_ready;

    modport master (
        output ev_valid,
        output ev_op,
        output ev_data,
        input  ev_ready
    );

    modport slave (
        input  ev_valid,
        input  ev_op,
        input  ev_data,
        output ev_ready
    );
endinterface

// File: rtl/led_event_sequencer.sv
// rtl/led_event_sequencer.sv - buffers ALU events and shows them as timed op/data phases on 8 LEDs
module led_event_sequencer #(
    parameter int HOLD_CYCLES = 50_000_000,
    parameter int GAP_CYCLES  = 12_500_000,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    led_event_sequencer_if.slave          ev_if,
    input  logic                          ovf_clr,
    output logic [7:0]                    LED,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          overflow,
    output logic [7:0]                    drop_count
);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int LW   = AW + 1;
    localparam int MAXC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);
    localparam logic [LW-1:0] FULL_LVL  = LW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SHOW_OP   = 2'd1,
        SHOW_DATA = 2'd2,
        GAP       = 2'd3
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [7:0]      r_led;
    logic [7:0]      r_data;
    logic            r_busy;

    logic [9:0]      r_mem [FIFO_DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [LW-1:0]   r_level;

    logic            r_overflow;
    logic [7:0]      r_drop_count;

    logic            w_full;
    logic            w_nonempty;
    logic            w_push;
    logic            w_drop;
    logic            w_pop;
    logic [9:0]      w_head;

    // LED layout for the op phase: marker bit 7 plus a one-hot op code in the low nibble
    function automatic logic [7:0] op_pattern(input logic [1:0] op);
        return {4'b1000, 4'b0001 << op};
    endfunction

    assign w_full     = (r_level == FULL_LVL);
    assign w_nonempty = (r_level != '0);
    assign w_push     = ev_if.ev_valid && !w_full;
    assign w_drop     = ev_if.ev_valid && w_full;
    assign w_head     = r_mem[r_rd_ptr];

    // The FSM takes the head exactly when leaving IDLE or finishing a gap with work pending
    assign w_pop = w_nonempty &&
                   ((r_state == IDLE) || ((r_state == GAP) && (r_cnt == GAP_LAST)));

    assign ev_if.ev_ready = !w_full;
    assign LED            = r_led;
    assign busy           = r_busy;
    assign level          = r_level;
    assign overflow       = r_overflow;
    assign drop_count     = r_drop_count;

    // Event storage; contents need no reset because occupancy gates every read
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {ev_if.ev_op, ev_if.ev_data};
        end
    end

    // FIFO pointers and occupancy; a simultaneous push and pop leaves the level unchanged
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    // Loss reporting; a drop in the same cycle as a clear restarts the count at one
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_overflow   <= 1'b0;
            r_drop_count <= 8'h00;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            if (ovf_clr) begin
                r_drop_count <= 8'h01;
            end else if (r_drop_count != 8'hFF) begin
                r_drop_count <= r_drop_count + 8'h01;
            end
        end else if (ovf_clr) begin
            r_overflow   <= 1'b0;
            r_drop_count <= 8'h00;
        end
    end

    // Display sequencer: op phase, data phase, blank gap, with LED and busy registered
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_led   <= 8'h00;
            r_data  <= 8'h00;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_nonempty) begin
                        r_state <= SHOW_OP;
                        r_cnt   <= '0;
                        r_led   <= op_pattern(w_head[9:8]);
                        r_data  <= w_head[7:0];
                        r_busy  <= 1'b1;
                    end
                end
                SHOW_OP: begin
                    if (r_cnt == HOLD_LAST) begin
                        r_state <= SHOW_DATA;
                        r_cnt   <= '0;
                        r_led   <= r_data;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                SHOW_DATA: begin
                    if (r_cnt == HOLD_LAST) begin
                        r_state <= GAP;
                        r_cnt   <= '0;
                        r_led   <= 8'h00;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                GAP: begin
                    if (r_cnt == GAP_LAST) begin
                        r_cnt <= '0;
                        if (w_nonempty) begin
                            r_state <= SHOW_OP;
                            r_led   <= op_pattern(w_head[9:8]);
                            r_data  <= w_head[7:0];
                        end else begin
                            r_state <= IDLE;
                            r_led   <= 8'h00;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                    r_led   <= 8'h00;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_led_event_sequencer.sv
// tb/tb_led_event_sequencer.sv - directed self-checking bench for led_event_sequencer
module tb_led_event_sequencer;
    logic       clk;
    logic       reset;
    logic       ovf_clr;
    logic [7:0] LED;
    logic       busy;
    logic [2:0] level;
    logic       overflow;
    logic [7:0] drop_count;

    int checks;
    int errors;

    logic [7:0] exp_pat [4];

    led_event_sequencer_if ev_if ();

    led_event_sequencer #(
        .HOLD_CYCLES (4),
        .GAP_CYCLES  (2),
        .FIFO_DEPTH  (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .ev_if      (ev_if),
        .ovf_clr    (ovf_clr),
        .LED        (LED),
        .busy       (busy),
        .level      (level),
        .overflow   (overflow),
        .drop_count (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_set(input logic [1:0] op, input logic [7:0] d);
        ev_if.ev_valid = 1'b1;
        ev_if.ev_op    = op;
        ev_if.ev_data  = d;
    endtask

    task automatic do_reset();
        reset          = 1'b0;
        ev_if.ev_valid = 1'b0;
        ev_if.ev_op    = 2'b00;
        ev_if.ev_data  = 8'h00;
        ovf_clr        = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset          = 1'b0;
        ev_if.ev_valid = 1'b0;
        ovf_clr        = 1'b0;
        #3;
        checks++;
        if ({LED, busy, ev_if.ev_ready, level, overflow, drop_count} !==
            {8'h00, 1'b0, 1'b1, 3'd0, 1'b0, 8'h00}) begin
            errors++;
            $display("FAIL reset_async: LED=%h busy=%b rdy=%b lvl=%0d ovf=%b drop=%0d",
                     LED, busy, ev_if.ev_ready, level, overflow, drop_count);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++;
            if ({LED, busy, ev_if.ev_ready, level, overflow} !== {8'h00, 1'b0, 1'b1, 3'd0, 1'b0}) begin
                errors++;
                $display("FAIL reset_idle cycle %0d: LED=%h busy=%b rdy=%b lvl=%0d ovf=%b, need 00 0 1 0 0",
                         i, LED, busy, ev_if.ev_ready, level, overflow);
            end
        end
    endtask

    task automatic test_single();
        logic [7:0] exp_led;
        logic       exp_busy;
        do_reset();
        push_set(2'b00, 8'h0C);
        tick();
        ev_if.ev_valid = 1'b0;
        for (int e = 1; e <= 11; e++) begin
            tick();
            exp_led  = (e <= 4) ? 8'h81 : (e <= 8) ? 8'h0C : 8'h00;
            exp_busy = (e <= 10);
            checks++;
            if (LED !== exp_led || busy !== exp_busy) begin
                errors++;
                $display("FAIL single edge %0d: LED=%h busy=%b, need LED=%h busy=%b",
                         e, LED, busy, exp_led, exp_busy);
            end
        end
    endtask

    task automatic test_burst();
        logic [2:0] exp_lvl [6];
        int k;
        exp_lvl = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
        do_reset();
        for (int e = 0; e < 6; e++) begin
            push_set(2'(e % 4), 8'hA0 + 8'(e));
            checks++;
            if (ev_if.ev_ready !== (e < 5)) begin
                errors++;
                $display("FAIL burst_ready before edge %0d: got %b need %b", e, ev_if.ev_ready, (e < 5));
            end
            tick();
            checks++;
            if (level !== exp_lvl[e]) begin
                errors++;
                $display("FAIL burst_level edge %0d: got %0d need %0d", e, level, exp_lvl[e]);
            end
            if (e == 1) begin
                checks++;
                if (LED !== 8'h81) begin
                    errors++;
                    $display("FAIL burst_e0_op: got %h need 81", LED);
                end
            end
        end
        ev_if.ev_valid = 1'b0;
        checks++;
        if (overflow !== 1'b1 || drop_count !== 8'd1 || LED !== 8'hA0) begin
            errors++;
            $display("FAIL burst_drop: ovf=%b drop=%0d LED=%h, need 1 1 A0", overflow, drop_count, LED);
        end
        for (int e = 6; e <= 51; e++) begin
            tick();
            k = (e - 1) / 10;
            if ((e - 1) % 10 == 0 && k < 5) begin
                checks++;
                if (LED !== exp_pat[k % 4]) begin
                    errors++;
                    $display("FAIL burst_op e%0d edge %0d: got %h need %h", k, e, LED, exp_pat[k % 4]);
                end
            end
            if (e >= 5 && (e - 5) % 10 == 0 && (e - 5) / 10 < 5) begin
                checks++;
                if (LED !== 8'hA0 + 8'((e - 5) / 10)) begin
                    errors++;
                    $display("FAIL burst_data edge %0d: got %h need %h", e, LED, 8'hA0 + 8'((e - 5) / 10));
                end
            end
        end
        checks++;
        if (busy !== 1'b0 || level !== 3'd0) begin
            errors++;
            $display("FAIL burst_end: busy=%b lvl=%0d, need 0 0", busy, level);
        end
    endtask

    task automatic test_clear_vs_drop();
        do_reset();
        for (int e = 0; e < 5; e++) begin
            push_set(2'b11, 8'h50 + 8'(e));
            tick();
        end
        ovf_clr = 1'b1;
        tick();
        checks++;
        if (overflow !== 1'b1 || drop_count !== 8'd1) begin
            errors++;
            $display("FAIL clr_vs_drop: ovf=%b drop=%0d, need 1 1", overflow, drop_count);
        end
        ev_if.ev_valid = 1'b0;
        tick();
        ovf_clr = 1'b0;
        checks++;
        if (overflow !== 1'b0 || drop_count !== 8'd0) begin
            errors++;
            $display("FAIL clr_alone: ovf=%b drop=%0d, need 0 0", overflow, drop_count);
        end
        ev_if.ev_valid = 1'b1;
        for (int i = 0; i < 400; i++) begin
            tick();
        end
        ev_if.ev_valid = 1'b0;
        checks++;
        if (overflow !== 1'b1 || drop_count !== 8'd255) begin
            errors++;
            $display("FAIL drop_saturate: ovf=%b drop=%0d, need 1 255", overflow, drop_count);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int e = 0; e < 3; e++) begin
            push_set(2'b10, 8'h30 + 8'(e));
            tick();
        end
        ev_if.ev_valid = 1'b0;
        for (int e = 3; e <= 6; e++) begin
            tick();
        end
        checks++;
        if (LED !== 8'h30 || level !== 3'd2) begin
            errors++;
            $display("FAIL mid_pre: LED=%h lvl=%0d, need 30 2", LED, level);
        end
        reset = 1'b0;
        #2;
        checks++;
        if (LED !== 8'h00 || level !== 3'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_abort: LED=%h lvl=%0d busy=%b, need 00 0 0", LED, level, busy);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        for (int i = 0; i < 30; i++) begin
            tick();
            checks++;
            if (LED !== 8'h00 || busy !== 1'b0 || level !== 3'd0) begin
                errors++;
                $display("FAIL mid_quiet cycle %0d: LED=%h busy=%b lvl=%0d", i, LED, busy, level);
            end
        end
    endtask

    task automatic test_wrap();
        logic [1:0] op;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            op = 2'((i + 1) % 4);
            push_set(op, 8'(i));
            tick();
            ev_if.ev_valid = 1'b0;
            for (int j = 1; j <= 11; j++) begin
                tick();
                if (j == 1) begin
                    checks++;
                    if (LED !== exp_pat[op]) begin
                        errors++;
                        $display("FAIL wrap_op ev%0d: got %h need %h", i, LED, exp_pat[op]);
                    end
                end
                if (j == 5) begin
                    checks++;
                    if (LED !== 8'(i)) begin
                        errors++;
                        $display("FAIL wrap_data ev%0d: got %h need %h", i, LED, 8'(i));
                    end
                end
                if (j == 11) begin
                    checks++;
                    if (busy !== 1'b0) begin
                        errors++;
                        $display("FAIL wrap_idle ev%0d: busy=%b need 0", i, busy);
                    end
                end
            end
        end
        checks++;
        if (level !== 3'd0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL wrap_end: lvl=%0d ovf=%b, need 0 0", level, overflow);
        end
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        exp_pat        = '{8'h81, 8'h82, 8'h84, 8'h88};
        reset          = 1'b0;
        ovf_clr        = 1'b0;
        ev_if.ev_valid = 1'b0;
        ev_if.ev_op    = 2'b00;
        ev_if.ev_data  = 8'h00;
        test_reset();
        test_single();
        test_burst();
        test_clear_vs_drop();
        test_reset_mid();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
